// File: rtl/display_scan_ctrl_if.sv
// Signal bundle between a display-scan controller and the logic that feeds it values.
// Names are from the controller's side: i_* flow into it, o_* come out of it.
interface display_scan_ctrl_if;
  logic [15:0] i_value;
  logic        i_load;
  logic        i_lzb_en;
  logic [3:0]  o_nibble;
  logic [3:0]  o_digit_en_n;
  logic        o_frame_done;

  modport master (
    output i_value, i_load, i_lzb_en,
    input  o_nibble, o_digit_en_n, o_frame_done
  );

  modport slave (
    input  i_value, i_load, i_lzb_en,
    output o_nibble, o_digit_en_n, o_frame_done
  );
endinterface

// File: rtl/display_scan_ctrl.sv
// Four-digit multiplexed display scanner: blank/show slots per digit, shadowed value updates
// applied only at frame boundaries, and optional leading-zero blanking.
module display_scan_ctrl #(
  parameter int unsigned CLKS_PER_DIGIT = 25000,
  parameter int unsigned BLANK_CLKS     = 250
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  display_scan_ctrl_if.slave  io_bus
);

  localparam int unsigned CntW = $clog2(CLKS_PER_DIGIT);

  typedef enum logic {StBlank, StShow} state_e;

  state_e          r_state, w_state_nxt;
  logic [CntW-1:0] r_cnt, w_cnt_nxt;
  logic [1:0]      r_idx, w_idx_nxt;
  logic [15:0]     r_shadow, r_display, w_display_nxt;
  logic            r_pending;
  logic [3:0]      r_nibble, r_digit_en_n, w_digit_en_n_nxt;
  logic            r_frame_done;
  logic            w_slot_end, w_frame_end, w_lzb_off;

  always_comb begin
    w_slot_end    = (r_cnt == CntW'(CLKS_PER_DIGIT - 1));
    w_frame_end   = w_slot_end && (r_idx == 2'd3);
    w_cnt_nxt     = w_slot_end ? '0 : r_cnt + CntW'(1);
    w_idx_nxt     = w_slot_end ? r_idx + 2'd1 : r_idx;
    w_display_nxt = (w_frame_end && r_pending) ? r_shadow : r_display;

    w_state_nxt = r_state;
    unique case (r_state)
      StBlank: if (w_cnt_nxt == CntW'(BLANK_CLKS)) w_state_nxt = StShow;
      StShow:  if (w_slot_end)                     w_state_nxt = StBlank;
      default: w_state_nxt = StBlank;
    endcase

    // Digit k is dark when it and every more-significant nibble are zero; digit 0 always shows.
    w_lzb_off = io_bus.i_lzb_en && (w_idx_nxt != 2'd0) &&
                ((w_display_nxt >> {w_idx_nxt, 2'b00}) == 16'h0000);

    // Decided from next-cycle state so enables line up with cnt and drop the same edge
    // the nibble changes.
    w_digit_en_n_nxt = 4'hF;
    if (w_state_nxt == StShow && !w_lzb_off) w_digit_en_n_nxt[w_idx_nxt] = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state      <= StBlank;
      r_cnt        <= '0;
      r_idx        <= 2'd0;
      r_shadow     <= 16'h0000;
      r_display    <= 16'h0000;
      r_pending    <= 1'b0;
      r_nibble     <= 4'h0;
      r_digit_en_n <= 4'hF;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_idx        <= w_idx_nxt;
      r_display    <= w_display_nxt;
      r_digit_en_n <= w_digit_en_n_nxt;
      r_frame_done <= w_frame_end;
      // A load in the frame-end cycle wins over the clear, keeping the new value pending.
      r_pending    <= io_bus.i_load | (r_pending & ~w_frame_end);
      if (io_bus.i_load) r_shadow <= io_bus.i_value;
      if (w_slot_end) r_nibble <= w_display_nxt[{w_idx_nxt, 2'b00} +: 4];
    end
  end

  assign io_bus.o_nibble     = r_nibble;
  assign io_bus.o_digit_en_n = r_digit_en_n;
  assign io_bus.o_frame_done = r_frame_done;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl: scenario tasks plus a cycle-level reference model
// derived from elapsed clocks since reset.
module tb_display_scan_ctrl;

  localparam int unsigned Cpd       = 8;
  localparam int unsigned Blank     = 2;
  localparam int unsigned FrameClks = 4 * Cpd;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  display_scan_ctrl_if bus ();

  display_scan_ctrl #(
    .CLKS_PER_DIGIT(Cpd),
    .BLANK_CLKS    (Blank)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .io_bus (bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: position in the scan follows from clocks elapsed since reset.
  int unsigned m_t;
  logic [15:0] m_shadow, m_disp;
  bit          m_pend;
  logic [3:0]  exp_en, exp_nib;
  logic        exp_fd;

  always @(posedge clk) begin : model
    int unsigned slot, dig;
    if (!rst_n) begin
      m_t = 0; m_shadow = 16'h0; m_disp = 16'h0; m_pend = 1'b0;
    end else begin
      if ((m_t % FrameClks) == FrameClks - 1 && m_pend) begin
        m_disp = m_shadow;
        m_pend = 1'b0;
      end
      if (bus.i_load) begin
        m_shadow = bus.i_value;
        m_pend   = 1'b1;
      end
      m_t++;
    end
    slot    = m_t % Cpd;
    dig     = (m_t / Cpd) % 4;
    exp_fd  = (m_t != 0) && ((m_t % FrameClks) == 0);
    exp_nib = 4'(m_disp >> (4 * dig));
    if (slot < Blank || (bus.i_lzb_en && dig > 0 && (m_disp >> (4 * dig)) == 16'h0))
      exp_en = 4'hF;
    else
      exp_en = ~(4'b0001 << dig);
  end

  bit         chk_on = 1'b0;
  logic [3:0] prev_nib;

  always @(negedge clk) begin
    if (chk_on) begin
      checks++;
      if (bus.o_digit_en_n !== exp_en) begin
        errors++;
        $display("FAIL model_en t=%0d got=%h exp=%h", m_t, bus.o_digit_en_n, exp_en);
      end
      checks++;
      if (bus.o_nibble !== exp_nib) begin
        errors++;
        $display("FAIL model_nibble t=%0d got=%h exp=%h", m_t, bus.o_nibble, exp_nib);
      end
      checks++;
      if (bus.o_frame_done !== exp_fd) begin
        errors++;
        $display("FAIL model_frame_done t=%0d got=%b exp=%b", m_t, bus.o_frame_done, exp_fd);
      end
      checks++;
      if ($countones(~bus.o_digit_en_n) > 1) begin
        errors++;
        $display("FAIL onehot_en got=%b exp=at most one zero", bus.o_digit_en_n);
      end
      checks++;
      if (bus.o_nibble !== prev_nib && bus.o_digit_en_n !== 4'hF) begin
        errors++;
        $display("FAIL nibble_stable got=%h->%h with en=%b exp=no change while enabled",
                 prev_nib, bus.o_nibble, bus.o_digit_en_n);
      end
      prev_nib = bus.o_nibble;
    end
  end

  // Per-frame capture: enabled clocks and the nibble shown for each digit.
  int         on_cnt[4];
  logic [3:0] shown[4];
  int         fd_cnt;

  task automatic wait_frame();
    bit seen = 1'b0;
    for (int i = 0; i < 3 * FrameClks && !seen; i++) begin
      @(negedge clk);
      if (bus.o_frame_done === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL wait_frame got=no pulse exp=o_frame_done within %0d clocks", 3 * FrameClks);
    end
  endtask

  // Call at a frame-start negedge; returns at the next frame-start negedge.
  task automatic collect_frame();
    fd_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      on_cnt[k] = 0;
      shown[k]  = 4'hx;
    end
    for (int i = 0; i < FrameClks; i++) begin
      if (bus.o_frame_done === 1'b1) fd_cnt++;
      for (int k = 0; k < 4; k++) begin
        if (bus.o_digit_en_n[k] === 1'b0) begin
          on_cnt[k]++;
          shown[k] = bus.o_nibble;
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bus.i_load = 1'b0; bus.i_value = 16'h0; bus.i_lzb_en = 1'b0;
    repeat (3) @(negedge clk);
    chk_on = 1'b1;
    checks++;
    if (bus.o_digit_en_n !== 4'hF) begin
      errors++; $display("FAIL reset_en got=%h exp=f", bus.o_digit_en_n);
    end
    checks++;
    if (bus.o_nibble !== 4'h0) begin
      errors++; $display("FAIL reset_nibble got=%h exp=0", bus.o_nibble);
    end
    checks++;
    if (bus.o_frame_done !== 1'b0) begin
      errors++; $display("FAIL reset_frame_done got=%b exp=0", bus.o_frame_done);
    end
  endtask

  task automatic test_basic_load();
    logic [15:0] v = 16'h1A2F;
    rst_n = 1'b1; bus.i_load = 1'b1; bus.i_value = v;
    @(negedge clk);
    bus.i_load = 1'b0; bus.i_value = 16'h0;
    wait_frame();
    collect_frame();
    checks++;
    if (fd_cnt != 1 || bus.o_frame_done !== 1'b1) begin
      errors++;
      $display("FAIL frame_period got=%0d pulses/end=%b exp=1 pulse per %0d clocks",
               fd_cnt, bus.o_frame_done, FrameClks);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (on_cnt[k] != int'(Cpd - Blank) || shown[k] !== v[4*k +: 4]) begin
        errors++;
        $display("FAIL basic_digit%0d got=%0d clks nib=%h exp=%0d clks nib=%h",
                 k, on_cnt[k], shown[k], Cpd - Blank, v[4*k +: 4]);
      end
    end
  endtask

  task automatic test_lzb();
    logic [15:0] v = 16'h0030;
    bus.i_load = 1'b1; bus.i_value = v; bus.i_lzb_en = 1'b1;
    @(negedge clk);
    bus.i_load = 1'b0;
    wait_frame();
    collect_frame();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (on_cnt[k] != ((k < 2) ? int'(Cpd - Blank) : 0)) begin
        errors++;
        $display("FAIL lzb_on_digit%0d got=%0d exp=%0d", k, on_cnt[k],
                 (k < 2) ? int'(Cpd - Blank) : 0);
      end
    end
    bus.i_lzb_en = 1'b0;
    collect_frame();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (on_cnt[k] != int'(Cpd - Blank) || shown[k] !== v[4*k +: 4]) begin
        errors++;
        $display("FAIL lzb_off_digit%0d got=%0d nib=%h exp=%0d nib=%h", k, on_cnt[k],
                 shown[k], Cpd - Blank, v[4*k +: 4]);
      end
    end
  endtask

  task automatic test_last_wins();
    bus.i_load = 1'b1; bus.i_value = 16'h1111;
    @(negedge clk);
    bus.i_load = 1'b0;
    repeat (5) @(negedge clk);
    bus.i_load = 1'b1; bus.i_value = 16'h2222;
    @(negedge clk);
    bus.i_load = 1'b0;
    wait_frame();
    collect_frame();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (shown[k] !== 4'h2) begin
        errors++; $display("FAIL last_wins_digit%0d got=%h exp=2", k, shown[k]);
      end
    end
  endtask

  task automatic test_frame_end_load();
    repeat (FrameClks - 1) @(negedge clk);
    bus.i_load = 1'b1; bus.i_value = 16'h5555;
    @(negedge clk);
    bus.i_load = 1'b0;
    collect_frame();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (shown[k] !== 4'h2) begin
        errors++; $display("FAIL edge_load_old_digit%0d got=%h exp=2", k, shown[k]);
      end
    end
    collect_frame();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (shown[k] !== 4'h5) begin
        errors++; $display("FAIL edge_load_new_digit%0d got=%h exp=5", k, shown[k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] want;
    repeat (5) @(negedge clk);
    bus.i_load = 1'b1; bus.i_value = 16'h9999;
    @(negedge clk);
    bus.i_load = 1'b0;
    repeat (14) @(negedge clk);
    checks++;
    if (bus.o_digit_en_n !== 4'hB) begin
      errors++; $display("FAIL pre_reset_digit2 got=%h exp=b", bus.o_digit_en_n);
    end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.o_digit_en_n !== 4'hF || bus.o_nibble !== 4'h0 || bus.o_frame_done !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset got=en %h nib %h fd %b exp=en f nib 0 fd 0",
               bus.o_digit_en_n, bus.o_nibble, bus.o_frame_done);
    end
    rst_n = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      want = (i < int'(Blank) || i == 8) ? 4'hF : 4'hE;
      checks++;
      if (bus.o_digit_en_n !== want) begin
        errors++; $display("FAIL restart_cnt%0d got=%h exp=%h", i, bus.o_digit_en_n, want);
      end
    end
    wait_frame();
    collect_frame();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (shown[k] !== 4'h0) begin
        errors++; $display("FAIL reset_discard_digit%0d got=%h exp=0", k, shown[k]);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 12 * int'(FrameClks); i++) begin
      bus.i_value = 16'($urandom);
      bus.i_load  = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 39) == 0) bus.i_lzb_en = ~bus.i_lzb_en;
      @(negedge clk);
    end
    bus.i_load = 1'b0;
    repeat (2 * FrameClks) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_lzb();
    test_last_wins();
    test_frame_end_load();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/display_scan_ctrl.md
DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 The block SHALL have parameter CLKS_PER_DIGIT, default 25000, giving clocks per digit slot, including blanking.
REQ-002 The block SHALL have parameter BLANK_CLKS, default 250, giving all-digits-off clocks at the start of each slot; legal range 1 <= BLANK_CLKS < CLKS_PER_DIGIT.
REQ-003 The block SHALL have port i_clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 The block SHALL have port i_rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-005 The block SHALL have port i_value, input, 16 bits: four hex digits to show; digit 0 = [3:0] (rightmost), digit 3 = [15:12].
REQ-006 The block SHALL have port i_load, input, 1 bit: when high, the block captures i_value into the shadow register that cycle.
REQ-007 The block SHALL have port i_lzb_en, input, 1 bit: leading-zero blanking enable, sampled every cycle.
REQ-008 The block SHALL have port o_nibble, output, 4 bits: the current digit's value, fed to the registered 7-segment encoder.
REQ-009 The block SHALL have port o_digit_en_n, output, 4 bits: active-low digit enables, bit k = digit k, at most one low.
REQ-010 The block SHALL have port o_frame_done, output, 1 bit: a one-clock pulse at the end of each 4-digit frame.

Function
REQ-011 The block SHALL hold a slot counter cnt (0..CLKS_PER_DIGIT-1) and a digit index idx (0..3); cnt increments every clock.
REQ-012 When cnt = CLKS_PER_DIGIT-1, the block SHALL clear cnt to 0 and advance idx, wrapping 3->0.
REQ-013 The block SHALL run state BLANK for cnt < BLANK_CLKS and state SHOW otherwise; no other states exist.
REQ-014 In BLANK, the block SHALL drive o_digit_en_n = 4'hF.
REQ-015 In SHOW, the block SHALL drive bit idx of o_digit_en_n low and all other bits high, unless REQ-019 applies.
REQ-016 The block SHALL register o_nibble = display[4*idx+3 : 4*idx], updated on the clock where cnt returns to 0, so it changes only at the start of BLANK.
REQ-017 The block SHALL register o_digit_en_n, giving one clock of latency from the state decision; the encoder's one-clock output register is therefore settled before any digit enables.
REQ-018 The block SHALL keep two 16-bit registers, shadow and display, plus a pending flag; i_load high SHALL set shadow <= i_value and pending <= 1.
REQ-019 With i_lzb_en = 1, the block SHALL keep digit k (k = 1..3) off in SHOW if display nibbles k..3 are all zero; digit 0 is never blanked.
REQ-020 The block SHALL pulse o_frame_done high for exactly one clock when idx = 3 and cnt = CLKS_PER_DIGIT-1 (registered, visible the next clock).
REQ-021 In the frame-end cycle of REQ-020, if pending = 1, the block SHALL set display <= shadow and clear pending; display never changes mid-frame.
REQ-022 If i_load is high in the frame-end cycle, the block SHALL use the pre-load shadow for the display copy, store the new value in shadow, and leave pending = 1.
REQ-023 With multiple loads within one frame, the block SHALL keep only the last value (last-wins); no loads are counted or queued.
REQ-024 The block SHALL not let i_value changes without i_load affect any state.

Reset
REQ-025 With i_rst_n low at a clock edge, the block SHALL set cnt = 0, idx = 0, state = BLANK, shadow = display = 16'h0000, pending = 0, o_nibble = 4'h0, o_digit_en_n = 4'hF, o_frame_done = 0.
REQ-026 On reset mid-frame, the block SHALL abandon the current frame and discard pending loads; after release, the block SHALL restart at digit 0, BLANK.

Verification (CLKS_PER_DIGIT=8, BLANK_CLKS=2)
REQ-027 The bench SHALL cover: reset, then i_load with 16'h1A2F, lzb off -> frame 1 shows 0000, o_frame_done pulses every 32 clocks, frame 2 shows F,2,A,1 on digits 0..3, each enabled 6 of 8 clocks.
REQ-028 The bench SHALL cover: display 16'h0030, i_lzb_en=1 -> digits 0,1 enable, digits 2,3 stay 1 throughout SHOW; with lzb=0, all four enable.
REQ-029 The bench SHALL cover: loads 16'h1111 then 16'h2222 in the same frame -> next frame shows 2222 only.
REQ-030 The bench SHALL cover: a load of 16'h5555 coincident with the frame-end cycle (pending=0) -> the next frame keeps the old value, the frame after shows 5555.
REQ-031 The bench SHALL cover: i_rst_n low for 1 clock during digit 2 SHOW -> the next clock o_digit_en_n=4'hF, o_nibble=0, and digit 0 slot restarts from cnt=0.
REQ-032 The bench SHALL check on every clock that o_digit_en_n has at most one zero bit, and that o_nibble never changes while any enable is low.
